// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: fetch FSM states,
// the canonical NOP and the base opcode map used by the decoders.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential vs. branch/jump target,
// plus a word-alignment check on whichever address was chosen.
module pc_next_logic
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  // pc+4 wraps naturally at 2^32; a wrap is not treated as an error.
  always_comb begin
    pc_plus4   = pc + 32'd4;
    pc_next    = pc_src ? pc_target : pc_plus4;
    misaligned = (pc_next[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory, holds the fetched instruction and exposes its decode fields.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | one cycle after reset before the first request
//   FETCH   | imem_req high, waiting for imem_ready (timeout counted)
//   HOLD    | instruction valid, waiting for instr_ack to advance PC
//   ERROR   | misaligned target or memory timeout; only reset leaves
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
)
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        instr_ack,
  input  logic        PCSrc,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic [31:0] retired
);

  // Last wait count that is still tolerated; a miss in that cycle errors out.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state, state_next;
  logic [7:0]   tmo_cnt;
  logic [31:0]  pc_next;
  logic         misaligned;
  logic         ack_take;
  logic         fetch_done;
  logic         timed_out;

  pc_next_logic u_pc_next (
    .pc         (pc),
    .pc_src     (PCSrc),
    .pc_target  (pc_target),
    .pc_next    (pc_next),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  assign ack_take   = (state == S_HOLD) && instr_ack;
  assign fetch_done = (state == S_FETCH) && imem_ready;
  assign timed_out  = (state == S_FETCH) && !imem_ready && (tmo_cnt == TMO_LAST);

  assign imem_addr = pc;
  assign op        = instr[6:0];
  assign rd        = instr[11:7];
  assign f3        = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign f7        = instr[31:25];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)     state_next = S_HOLD;
        else if (timed_out) state_next = S_ERROR;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) state_next = misaligned ? S_ERROR : S_FETCH;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  // Instruction register: captured only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (reset)           instr <= NOP_INSTR;
    else if (fetch_done) instr <= imem_rdata;
  end

  // Program counter: advances on ack unless the new address is misaligned.
  always_ff @(posedge clk) begin
    if (reset)                         pc <= RESET_PC;
    else if (ack_take && !misaligned)  pc <= pc_next;
  end

  // Wait counter: counts missed FETCH cycles, zero whenever not waiting.
  always_ff @(posedge clk) begin
    if (reset)                                     tmo_cnt <= 8'd0;
    else if ((state == S_FETCH) && !imem_ready)    tmo_cnt <= tmo_cnt + 8'd1;
    else                                           tmo_cnt <= 8'd0;
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (reset)                                   fetch_err <= 1'b0;
    else if (timed_out || (ack_take && misaligned)) fetch_err <= 1'b1;
  end

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset)         retired <= 32'd0;
    else if (ack_take) retired <= retired + 32'd1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stream of fetch/ack transactions checked against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        instr_ack;
  logic        PCSrc;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: address of the instruction the DUT should be working on.
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_err;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr_ack   (instr_ack),
    .PCSrc       (PCSrc),
    .pc_target   (pc_target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .f3          (f3),
    .f7          (f7),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0; PCSrc = 1'b0;
    imem_rdata = $urandom(); pc_target = $urandom();
    step(); step();
    chk("rst_req",     32'(imem_req),    32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_instr",   instr,            NOP);
    chk("rst_pc",      pc,               RST_PC);
    chk("rst_err",     32'(fetch_err),   32'd0);
    chk("rst_retired", retired,          32'd0);
    reset = 1'b0;
    step();
    m_pc = RST_PC; m_retired = 32'd0; m_err = 1'b0;
  endtask

  // Serve one fetch after `delay` not-ready cycles, then check the held word.
  task automatic fetch_one(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      chk("wait_req",   32'(imem_req),    32'd1);
      chk("wait_addr",  imem_addr,        m_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      imem_ready = 1'b0; imem_rdata = $urandom();
      step();
    end
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr,     m_pc);
    imem_ready = 1'b1; imem_rdata = word;
    step();
    imem_ready = 1'b0; imem_rdata = $urandom();
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_req",   32'(imem_req),    32'd0);
    chk("hold_instr", instr,            word);
    chk("hold_op",    32'(op),          32'(word[6:0]));
    chk("hold_rd",    32'(rd),          32'(word[11:7]));
    chk("hold_f3",    32'(f3),          32'(word[14:12]));
    chk("hold_rs1",   32'(rs1),         32'(word[19:15]));
    chk("hold_rs2",   32'(rs2),         32'(word[24:20]));
    chk("hold_f7",    32'(f7),          32'(word[31:25]));
    chk("hold_pc",    pc,               m_pc);
    chk("hold_pc4",   pc_plus4,         m_pc + 32'd4);
    chk("hold_err",   32'(fetch_err),   32'd0);
  endtask

  // Hold for `wait_n` cycles without ack, then ack with the given redirect.
  task automatic hold_ack(input int wait_n, input logic src, input logic [31:0] tgt);
    logic [31:0] held;
    logic [31:0] nxt;
    held = instr;
    for (int i = 0; i < wait_n; i++) begin
      instr_ack = 1'b0; PCSrc = 1'($urandom()); pc_target = $urandom();
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr,            held);
      chk("stall_pc",    pc,               m_pc);
    end
    instr_ack = 1'b1; PCSrc = src; pc_target = tgt;
    step();
    instr_ack = 1'b0; PCSrc = 1'($urandom()); pc_target = $urandom();
    nxt = src ? tgt : (m_pc + 32'd4);
    m_retired = m_retired + 32'd1;
    chk("ack_retired", retired, m_retired);
    if (nxt % 4 != 0) begin
      m_err = 1'b1;
      chk("mis_err",   32'(fetch_err),   32'd1);
      chk("mis_req",   32'(imem_req),    32'd0);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      chk("mis_pc",    pc,               m_pc);
    end else begin
      m_pc = nxt;
      chk("ack_req",  32'(imem_req),  32'd1);
      chk("ack_addr", imem_addr,      m_pc);
      chk("ack_err",  32'(fetch_err), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0; PCSrc = 1'b0;
    imem_rdata = 32'd0; pc_target = 32'd0;

    // Straight-line fetch of three words, first is addi x1, x0, 10.
    do_reset();
    fetch_one(0, 32'h00A0_0093);
    chk("addi_op",  32'(op),  32'h13);
    chk("addi_rd",  32'(rd),  32'd1);
    chk("addi_rs1", 32'(rs1), 32'd0);
    chk("addi_f3",  32'(f3),  32'd0);
    hold_ack(0, 1'b0, 32'd0);
    fetch_one(0, $urandom());
    hold_ack(0, 1'b0, 32'd0);
    fetch_one(0, $urandom());
    hold_ack(0, 1'b0, 32'd0);
    chk("three_retired", retired, 32'd3);
    chk("three_addr",    imem_addr, 32'd12);

    // Reset while a ready response arrives in the same cycle.
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0; imem_ready = 1'b0;
    chk("midrst_instr", instr,            NOP);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc",    pc,               RST_PC);
    chk("midrst_req",   32'(imem_req),    32'd0);
    chk("midrst_ret",   retired,          32'd0);
    step();
    m_pc = RST_PC; m_retired = 32'd0; m_err = 1'b0;
    chk("refetch_req",  32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr,     RST_PC);

    // Taken redirect, then a misaligned one that must park in ERROR.
    fetch_one(0, $urandom());
    hold_ack(1, 1'b1, 32'h0000_0040);
    chk("jump_addr", imem_addr, 32'h40);
    fetch_one(2, $urandom());
    hold_ack(0, 1'b1, 32'h0000_0042);
    chk("mis_pc_kept", pc, 32'h40);
    imem_ready = 1'b1; instr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", 32'(fetch_err), 32'd1);
      chk("err_noreq",  32'(imem_req),  32'd0);
      chk("err_pc",     pc,             32'h40);
    end
    imem_ready = 1'b0; instr_ack = 1'b0;

    // Memory never answers: error at the edge ending the TMO-th FETCH cycle.
    do_reset();
    imem_ready = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k < TMO) begin
        chk("tmo_early_err", 32'(fetch_err), 32'd0);
        chk("tmo_early_req", 32'(imem_req),  32'd1);
      end else begin
        chk("tmo_err", 32'(fetch_err), 32'd1);
        chk("tmo_req", 32'(imem_req),  32'd0);
      end
    end

    // Longest tolerated wait, then pc+4 wrap past the top of memory.
    do_reset();
    fetch_one(TMO - 1, $urandom());
    hold_ack(0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(0, $urandom());
    chk("wrap_pc4", pc_plus4, 32'd0);
    hold_ack(0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    // Random transaction stream.
    for (int n = 0; n < 60; n++) begin
      fetch_one(int'($urandom_range(0, TMO - 1)), $urandom());
      t = $urandom();
      t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hold_ack(int'($urandom_range(0, 2)), 1'($urandom()), t);
      if (m_err) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of the control unit. It owns the program counter, issues word requests to instruction memory over a ready handshake, holds the fetched instruction in an instruction register, and splits it into the op/f3/f7/register fields consumed by the control unit and datapath. It consumes the control unit's `PCSrc` and the datapath's branch/jump target to choose the next PC once the current instruction is acknowledged.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT`, 16, maximum consecutive FETCH cycles without `imem_ready` before a bus error; range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  32  word address; equals `pc` in every state.
- `imem_rdata`  in  32  instruction word; valid in a cycle where `imem_ready`=1.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `instr_ack`  in  1  downstream has finished the held instruction.
- `PCSrc`  in  1  take `pc_target` instead of `pc`+4.
- `pc_target`  in  32  branch/jump target.
- `instr_valid`  out  1  instruction register holds a valid instruction.
- `instr`  out  32  instruction register.
- `op`  out  7  `instr[6:0]`.
- `f3`  out  3  `instr[14:12]`.
- `f7`  out  7  `instr[31:25]`.
- `rs1`, `rs2`, `rd`  out  5 each  `instr[19:15]`, `[24:20]`, `[11:7]`.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc`+4, modulo 2^32.
- `fetch_err`  out  1  sticky: misaligned target or memory timeout.
- `retired`  out  32  count of acknowledged instructions, wraps.

## Operation
- States: IDLE, FETCH, HOLD, ERROR.
- Reset (any state, including with a request outstanding): state IDLE, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `fetch_err`=0, `retired`=0, timeout counter 0.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH: `imem_req`=1. If `imem_ready`, then `instr`<=`imem_rdata` and go to HOLD. Otherwise increment the timeout counter. Once it reaches `TIMEOUT`, set `fetch_err` and go to ERROR. The counter clears on entering FETCH.
- HOLD: `instr_valid`=1. `instr` and `pc` are stable.
  - On `instr_ack`: `retired`++. Next PC = `PCSrc` ? `pc_target` : `pc`+4.
  - If the next PC has bits [1:0]≠0: `pc` is unchanged, `fetch_err`<=1, go to ERROR.
  - Otherwise `pc`<=next PC and go to FETCH.
- ERROR: `imem_req`=0, `instr_valid`=0. Only `reset` exits this state.
- Inputs ignored outside their state: `imem_ready` outside FETCH, `instr_ack` outside HOLD. `PCSrc` and `pc_target` are sampled only when `instr_ack` is high in HOLD.
- The field outputs are combinational slices of `instr` and are valid whenever `instr_valid`=1.

## Timing
- First `imem_req` in the first cycle after `reset` deasserts plus one (the IDLE cycle).
- Fetch latency: `imem_ready` in cycle N → `instr_valid`=1 in cycle N+1.
- Best-case throughput: one instruction per 2 cycles (FETCH, HOLD), with ready and ack immediate.
- `instr_ack` in cycle N → `imem_req`=1 with the new `imem_addr` in cycle N+1.
- Timeout: with `imem_ready` held low, `fetch_err` rises at the edge ending the `TIMEOUT`-th FETCH cycle.
- `retired` wraps from 32'hFFFF_FFFF to 0. `pc`+4 wraps from 32'hFFFF_FFFC to 0 with no error.

## Structure
- Shared package `riscv_pkg` holds:
  - the state enum `fetch_state_t`;
  - `NOP_INSTR` (32'h0000_0013);
  - the opcode constants that are also used by the decoders.
- One sub-module, `pc_next_logic`, is combinational: it takes `pc`, `PCSrc` and `pc_target` and produces the next PC, `pc_plus4` and the misalignment flag.
- The FSM, instruction register, timeout counter and `retired` counter stay in `fetch_unit`.

## Test plan
- Reset, then memory always ready, ack asserted in every HOLD, `PCSrc`=0 → addresses 0, 4, 8 issued every 2 cycles and `retired`=3 after the third ack.
- Load 32'h00A00093 at address 0 → `op`=7'h13, `rd`=1, `rs1`=0, `f3`=0, `instr_valid` one cycle after ready.
- Ack with `PCSrc`=1, `pc_target`=32'h0000_0040 → next `imem_addr`=32'h40. With `pc_target`=32'h42 → `fetch_err`=1, ERROR state, `pc` unchanged, `imem_req`=0.
- With `TIMEOUT`=4 and `imem_ready` held low → `fetch_err` after 4 FETCH cycles. Ready with a 3-cycle delay → no error.
- `reset` asserted mid-FETCH while `imem_ready` rises in the same cycle → `instr` stays NOP, `pc`=`RESET_PC`, refetch from `RESET_PC`.
